// File: rtl/waveform_burst_gen.sv
// Burst waveform generator: emits LANES copies of a pulse amplitude for D cycles,
// then a baseline amplitude for Z cycles, repeated for a counted or continuous burst.
module waveform_burst_gen #(
    parameter int LANES = 12,
    parameter int DW    = 16,
    parameter int CW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       i_valid_amp,
    input  logic [DW-1:0]       i_zero_amp,
    input  logic [CW-1:0]       i_data_duration,
    input  logic [CW-1:0]       i_zero_duration,
    input  logic [CW-1:0]       i_burst_cnt,
    input  logic                i_trigger,
    input  logic                i_stop,
    input  logic                i_abort,
    output logic [LANES*DW-1:0] out_data,
    output logic                o_busy,
    output logic                o_done,
    output logic [CW-1:0]       o_period_cnt
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_DATA = 2'd1,
        OUT_ZERO = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          trig_q, stop_q;
    logic          trig_edge, stop_edge;
    logic [DW-1:0] valid_amp_s, zero_amp_s;
    logic [CW-1:0] data_dur_s, zero_dur_s, burst_s;
    logic [CW-1:0] phase_cnt, period_cnt, period_inc;
    logic          stop_pend, done_q;
    logic          last_data, last_zero, burst_hit, finish;

    assign trig_edge  = i_trigger & ~trig_q;
    assign stop_edge  = i_stop & ~stop_q;
    assign period_inc = period_cnt + ONE;
    // Shadow durations are stored already clamped to at least one cycle.
    assign last_data  = (state == OUT_DATA) && (phase_cnt == data_dur_s - ONE);
    assign last_zero  = (state == OUT_ZERO) && (phase_cnt == zero_dur_s - ONE);
    assign burst_hit  = (burst_s != '0) && (period_inc == burst_s);
    assign finish     = last_zero && (stop_pend || stop_edge || burst_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (trig_edge) state_nxt = OUT_DATA;
                OUT_DATA: if (last_data) state_nxt = OUT_ZERO;
                OUT_ZERO: if (last_zero) state_nxt = finish ? IDLE : OUT_DATA;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: edge detectors, shadow registers, phase/period counters, stop and done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q      <= 1'b0;
            stop_q      <= 1'b0;
            valid_amp_s <= '0;
            zero_amp_s  <= '0;
            data_dur_s  <= '0;
            zero_dur_s  <= '0;
            burst_s     <= '0;
            phase_cnt   <= '0;
            period_cnt  <= '0;
            stop_pend   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            trig_q <= i_trigger;
            stop_q <= i_stop;
            done_q <= ~i_abort & finish;
            if (i_abort) begin
                phase_cnt <= '0;
                stop_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        stop_pend <= 1'b0;
                        if (trig_edge) begin
                            valid_amp_s <= i_valid_amp;
                            zero_amp_s  <= i_zero_amp;
                            data_dur_s  <= (i_data_duration == '0) ? ONE : i_data_duration;
                            zero_dur_s  <= (i_zero_duration == '0) ? ONE : i_zero_duration;
                            burst_s     <= i_burst_cnt;
                            phase_cnt   <= '0;
                            period_cnt  <= '0;
                        end
                    end
                    OUT_DATA: begin
                        phase_cnt <= last_data ? '0 : phase_cnt + ONE;
                        if (stop_edge) stop_pend <= 1'b1;
                    end
                    OUT_ZERO: begin
                        if (last_zero) begin
                            phase_cnt  <= '0;
                            period_cnt <= period_inc;
                        end else begin
                            phase_cnt <= phase_cnt + ONE;
                        end
                        if (finish) begin
                            stop_pend <= 1'b0;
                        end else if (stop_edge) begin
                            stop_pend <= 1'b1;
                        end
                    end
                    default: phase_cnt <= '0;
                endcase
            end
        end
    end

    always_comb begin
        o_busy       = (state != IDLE);
        o_done       = done_q;
        o_period_cnt = period_cnt;
        case (state)
            OUT_DATA: out_data = {LANES{valid_amp_s}};
            OUT_ZERO: out_data = {LANES{zero_amp_s}};
            default:  out_data = {LANES{i_zero_amp}};
        endcase
    end

endmodule

// File: tb/tb_waveform_burst_gen.sv
// Directed testbench for waveform_burst_gen: counted bursts, continuous mode with stop,
// abort, zero durations, shadowing and asynchronous reset.
module tb_waveform_burst_gen;

    localparam int LANES = 12;
    localparam int DW    = 16;
    localparam int CW    = 32;
    localparam int OW    = LANES * DW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] i_valid_amp, i_zero_amp;
    logic [CW-1:0] i_data_duration, i_zero_duration, i_burst_cnt;
    logic          i_trigger, i_stop, i_abort;
    logic [OW-1:0] out_data;
    logic          o_busy, o_done;
    logic [CW-1:0] o_period_cnt;

    int compared   = 0;
    int mismatched = 0;

    waveform_burst_gen #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid_amp     (i_valid_amp),
        .i_zero_amp      (i_zero_amp),
        .i_data_duration (i_data_duration),
        .i_zero_duration (i_zero_duration),
        .i_burst_cnt     (i_burst_cnt),
        .i_trigger       (i_trigger),
        .i_stop          (i_stop),
        .i_abort         (i_abort),
        .out_data        (out_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_period_cnt    (o_period_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OW-1:0] rep(input logic [DW-1:0] a);
        return {LANES{a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] va, input logic [DW-1:0] za,
                                 input int d, input int z, input int n);
        i_valid_amp     = va;
        i_zero_amp      = za;
        i_data_duration = CW'(d);
        i_zero_duration = CW'(z);
        i_burst_cnt     = CW'(n);
    endtask

    task automatic checkOutput(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic startBurst();
        i_trigger = 1'b1;
        tick();
        i_trigger = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_trigger = 1'b0;
        i_stop    = 1'b0;
        i_abort   = 1'b0;
        applyStimulus(16'h1234, 16'h0055, 4, 2, 3);
        #1;
        checkOutput("rst_busy", OW'(o_busy), OW'(0));
        checkOutput("rst_done", OW'(o_done), OW'(0));
        checkOutput("rst_period", OW'(o_period_cnt), OW'(0));
        checkOutput("rst_out", out_data, rep(16'h0055));
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] burst of three D=4 Z=2 N=3");

        startBurst();
        for (int c = 1; c <= 18; c++) begin
            checkOutput($sformatf("b3_out_c%0d", c), out_data,
                        (((c - 1) % 6) < 4) ? rep(16'h1234) : rep(16'h0055));
            checkOutput($sformatf("b3_busy_c%0d", c), OW'(o_busy), OW'(1));
            checkOutput($sformatf("b3_done_c%0d", c), OW'(o_done), OW'(0));
            tick();
        end
        checkOutput("b3_end_busy", OW'(o_busy), OW'(0));
        checkOutput("b3_end_done", OW'(o_done), OW'(1));
        checkOutput("b3_end_period", OW'(o_period_cnt), OW'(3));
        checkOutput("b3_end_out", out_data, rep(16'h0055));
        tick();
        checkOutput("b3_done_one_cycle", OW'(o_done), OW'(0));

        $display("[TB] continuous mode with stop");
        applyStimulus(16'h0F0F, 16'h0003, 2, 3, 0);
        startBurst();
        for (int c = 1; c <= 25; c++) begin
            checkOutput($sformatf("cont_busy_c%0d", c), OW'(o_busy), OW'(1));
            checkOutput($sformatf("cont_done_c%0d", c), OW'(o_done), OW'(0));
            if (c == 22) i_stop = 1'b1;
            if (c == 23) i_stop = 1'b0;
            tick();
        end
        checkOutput("cont_end_busy", OW'(o_busy), OW'(0));
        checkOutput("cont_end_done", OW'(o_done), OW'(1));
        checkOutput("cont_end_period", OW'(o_period_cnt), OW'(5));
        tick();
        checkOutput("cont_done_one_cycle", OW'(o_done), OW'(0));

        $display("[TB] abort mid data");
        applyStimulus(16'h00AA, 16'h0011, 4, 2, 0);
        startBurst();
        for (int c = 1; c < 7; c++) tick();
        checkOutput("abort_period_c7", OW'(o_period_cnt), OW'(1));
        tick();
        checkOutput("abort_out_c8", out_data, rep(16'h00AA));
        i_abort = 1'b1;
        tick();
        checkOutput("abort_busy", OW'(o_busy), OW'(0));
        checkOutput("abort_done", OW'(o_done), OW'(0));
        checkOutput("abort_period_hold", OW'(o_period_cnt), OW'(1));
        checkOutput("abort_out_idle", out_data, rep(16'h0011));
        i_abort = 1'b0;
        tick();
        checkOutput("abort_done_after", OW'(o_done), OW'(0));
        checkOutput("abort_busy_after", OW'(o_busy), OW'(0));

        i_trigger = 1'b1;
        i_abort   = 1'b1;
        tick();
        checkOutput("abort_beats_trigger", OW'(o_busy), OW'(0));
        i_abort = 1'b0;
        tick();
        checkOutput("held_trigger_no_edge", OW'(o_busy), OW'(0));
        checkOutput("held_trigger_period", OW'(o_period_cnt), OW'(1));
        i_trigger = 1'b0;
        tick();

        $display("[TB] zero durations");
        applyStimulus(16'h7777, 16'h0101, 0, 0, 2);
        startBurst();
        checkOutput("zd_out_c1", out_data, rep(16'h7777));
        checkOutput("zd_busy_c1", OW'(o_busy), OW'(1));
        tick();
        checkOutput("zd_out_c2", out_data, rep(16'h0101));
        tick();
        checkOutput("zd_out_c3", out_data, rep(16'h7777));
        tick();
        checkOutput("zd_out_c4", out_data, rep(16'h0101));
        checkOutput("zd_busy_c4", OW'(o_busy), OW'(1));
        tick();
        checkOutput("zd_busy_c5", OW'(o_busy), OW'(0));
        checkOutput("zd_done_c5", OW'(o_done), OW'(1));
        checkOutput("zd_period_c5", OW'(o_period_cnt), OW'(2));

        $display("[TB] shadowing and busy retrigger");
        applyStimulus(16'h0AAA, 16'h0111, 3, 2, 2);
        startBurst();
        for (int c = 1; c <= 10; c++) begin
            checkOutput($sformatf("sh_out_c%0d", c), out_data,
                        (((c - 1) % 5) < 3) ? rep(16'h0AAA) : rep(16'h0111));
            checkOutput($sformatf("sh_busy_c%0d", c), OW'(o_busy), OW'(1));
            if (c == 2) begin
                i_valid_amp     = 16'h0BBB;
                i_data_duration = CW'(1);
                i_trigger       = 1'b1;
            end
            if (c == 3) i_trigger = 1'b0;
            tick();
        end
        checkOutput("sh_end_busy", OW'(o_busy), OW'(0));
        checkOutput("sh_end_done", OW'(o_done), OW'(1));
        checkOutput("sh_end_period", OW'(o_period_cnt), OW'(2));
        startBurst();
        checkOutput("sh_new_amp", out_data, rep(16'h0BBB));
        tick();
        checkOutput("sh_new_dur", out_data, rep(16'h0111));
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();

        $display("[TB] reset mid zero phase");
        applyStimulus(16'h4321, 16'h0222, 1, 3, 2);
        startBurst();
        for (int c = 1; c < 7; c++) tick();
        checkOutput("rz_out_c7", out_data, rep(16'h0222));
        checkOutput("rz_busy_c7", OW'(o_busy), OW'(1));
        checkOutput("rz_period_c7", OW'(o_period_cnt), OW'(1));
        rst = 1'b1;
        #1;
        checkOutput("rz_async_busy", OW'(o_busy), OW'(0));
        checkOutput("rz_async_done", OW'(o_done), OW'(0));
        checkOutput("rz_async_period", OW'(o_period_cnt), OW'(0));
        checkOutput("rz_async_out", out_data, rep(16'h0222));
        i_zero_amp = 16'h0333;
        #1;
        checkOutput("rz_out_follows", out_data, rep(16'h0333));
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checkOutput($sformatf("rz_post_done_%0d", c), OW'(o_done), OW'(0));
            checkOutput($sformatf("rz_post_busy_%0d", c), OW'(o_busy), OW'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
